bus_burst_reader: RTL and testbench
===================================

// Module: bus_burst_reader
// PURPOSE
//  Bus initiator that streams a block of 16-bit words out of RAM into a local FIFO for a peripheral consumer (VGA line fetch, ID 2).
//  Sits on the shared system bus beside the CPU and uses the same req/ack/wait handshake, issuing read bursts to the SRAM controller.
//  Software/peripheral gives base address + length and pulses start; the block refills the FIFO whenever room for a full burst exists.
// PARAMETERS
//  A_WIDTH     32   bus byte-address width
//  D_WIDTH     16   bus data / FIFO word width
//  FIFO_DEPTH  32   FIFO entries, power of 2, >= 2*BURST_WORDS
//  LEN_WIDTH   16   width of word-count request
//  BURST_CODE  2'b10  bus_burst_length for full bursts; 00=1, 01=4, 10=8, 11=16 words (BURST_WORDS derived)
// PORTS
//  clk               in   1          system clock, all logic rising-edge
//  reset             in   1          asynchronous, active-high reset
//  start             in   1          1-cycle pulse: begin transfer (ignored while busy)
//  abort             in   1          1-cycle pulse: stop transfer, flush FIFO
//  base_addr         in   A_WIDTH    byte address of first word, bit 0 ignored (treated 0)
//  num_words         in   LEN_WIDTH  words to read; 0 => immediate done, no bus activity
//  busy              out  1          transfer in progress
//  done              out  1          1-cycle pulse after last word written to FIFO or abort completes
//  bus_req           out  1          request to arbiter
//  bus_ack           in   1          this initiator's grant bit
//  bus_wait          in   1          responder not ready; data invalid while high
//  bus_write         out  1          constant 0 (read-only initiator)
//  bus_burst_length  out  2          burst code of current transaction
//  bus_addr          out  A_WIDTH    start byte address of current transaction
//  bus_data_in       in   D_WIDTH    read data from bus mux
//  fifo_rd           in   1          pop head word (ignored when empty)
//  fifo_dout         out  D_WIDTH    head word, show-ahead, valid when !fifo_empty
//  fifo_empty        out  1          FIFO empty
//  fifo_count        out  log2(FIFO_DEPTH)+1  words held
// BEHAVIOUR
//  Reset: bus_req=0, bus_addr=0, bus_burst_length=00, busy=0, done=0, fifo_count=0, fifo_empty=1, state IDLE; fifo_dout don't-care.
//  States: IDLE -> CHECK -> REQ -> DATA -> RELEASE -> CHECK ... -> FINISH -> IDLE.
//  IDLE: start latches addr (bit0 cleared) and remaining=num_words, busy=1 next cycle; num_words=0 -> FINISH directly.
//  CHECK: if remaining=0 -> FINISH. Else len=BURST_WORDS if remaining>=BURST_WORDS (code BURST_CODE), else len=1 (code 00).
//         Go REQ only when FIFO_DEPTH-fifo_count >= len (counted at this edge); otherwise stay. FIFO can never overflow.
//  REQ: bus_req=1, bus_addr/bus_burst_length stable from entry until RELEASE; on bus_ack=1 -> DATA.
//  DATA: word accepted on each edge with bus_ack=1 && bus_wait=0; pushed to FIFO same edge. After len-th word:
//         bus_req=0 next cycle, addr += 2*len, remaining -= len, -> RELEASE.
//  RELEASE: wait for bus_ack=0 (>=1 cycle), then CHECK. Back-to-back bursts always re-arbitrate.
//  FINISH: done=1 for one cycle, busy=0, -> IDLE.
//  Latency: start to bus_req high = 2 cycles when FIFO has room.
//  FIFO: simultaneous push+pop when full-minus-room or empty legal; count unchanged, pop returns old head.
//  Pop on empty: ignored, count stays 0. Pointers wrap modulo FIFO_DEPTH.
//  Abort: in IDLE/CHECK/REQ-without-ack: drop req, flush FIFO, done pulse, IDLE next cycle.
//         In DATA: finish current burst (responder must not be cut), discard its words, then flush and done. start during abort ignored.
//  bus_addr arithmetic wraps modulo 2^A_WIDTH. Reset mid-transfer clears everything immediately, req drops asynchronously.
// TESTING
//  1. base=0x100, num=16, BURST_CODE=10, slave wait=2 cycles -> two reqs, addrs 0x100 then 0x110, code 10, 16 words in order, done once.
//  2. num=11 -> bursts: 8 words @base, then three 1-word reads @base+0x10,+0x12,+0x14 code 00; fifo_count=11; done.
//  3. Consumer stalled, num=64, DEPTH=32 -> 4 bursts then bus_req stays 0 with count=32; pop 8 -> next burst issues; no overflow.
//  4. Abort asserted mid-burst at word 3 -> remaining 5 words accepted then discarded, req low, FIFO empty, one done pulse.
//  5. num=0 start -> done 2 cycles later, bus_req never asserted; start while busy -> ignored, addresses unchanged.
//  6. reset asserted during DATA -> bus_req=0 same cycle, count=0, busy=0; new start afterwards reads from fresh base correctly.

Source files
------------

// File: rtl/bus_burst_reader.sv
// Bus read initiator: fetches num_words 16-bit words from base_addr in full or
// single-word bursts and queues them in a show-ahead FIFO for a local consumer.
module bus_burst_reader #(
    parameter int unsigned A_WIDTH    = 32,
    parameter int unsigned D_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter logic [1:0]  BURST_CODE = 2'b10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [A_WIDTH-1:0]            base_addr,
    input  logic [LEN_WIDTH-1:0]          num_words,
    output logic                          busy,
    output logic                          done,
    output logic                          bus_req,
    input  logic                          bus_ack,
    input  logic                          bus_wait,
    output logic                          bus_write,
    output logic [1:0]                    bus_burst_length,
    output logic [A_WIDTH-1:0]            bus_addr,
    input  logic [D_WIDTH-1:0]            bus_data_in,
    input  logic                          fifo_rd,
    output logic [D_WIDTH-1:0]            fifo_dout,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BURST_WORDS =
        (BURST_CODE == 2'b00) ? 1 : (1 << (32'(BURST_CODE) + 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DATA,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t               state;
    logic                 aborting;
    logic [LEN_WIDTH-1:0] remaining;
    logic [4:0]           cur_len;
    logic [4:0]           beat;

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [D_WIDTH-1:0]   mem [FIFO_DEPTH];

    logic                 full_burst;
    logic [4:0]           next_len;
    logic [1:0]           next_code;
    logic                 room_ok;
    logic                 beat_in;
    logic                 push;
    logic                 pop;
    logic                 flush;

    assign bus_write  = 1'b0;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_dout  = mem[rd_ptr];

    always_comb begin
        full_burst = (remaining >= LEN_WIDTH'(BURST_WORDS));
        next_len   = full_burst ? 5'(BURST_WORDS) : 5'd1;
        next_code  = full_burst ? BURST_CODE : 2'b00;
        room_ok    = ((CW'(FIFO_DEPTH) - fifo_count) >= CW'(next_len));
        beat_in    = bus_ack && !bus_wait;
        // Words of a burst that is being aborted still complete on the bus but are dropped here
        push       = (state == S_DATA) && beat_in && !aborting && !abort;
        pop        = fifo_rd && (fifo_count != '0);
        flush      = (abort && ((state == S_IDLE) || (state == S_CHECK) ||
                                (state == S_FINISH) ||
                                ((state == S_REQ) && !bus_ack))) ||
                     ((state == S_RELEASE) && !bus_ack && (aborting || abort));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus_req          <= 1'b0;
            bus_addr         <= '0;
            bus_burst_length <= 2'b00;
            remaining        <= '0;
            cur_len          <= '0;
            beat             <= '0;
            aborting         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (abort) begin
                        done <= 1'b1;
                    end else if (start) begin
                        bus_addr  <= {base_addr[A_WIDTH-1:1], 1'b0};
                        remaining <= num_words;
                        busy      <= 1'b1;
                        state     <= (num_words == '0) ? S_FINISH : S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (remaining == '0) begin
                        state <= S_FINISH;
                    end else if (room_ok) begin
                        cur_len          <= next_len;
                        bus_burst_length <= next_code;
                        beat             <= '0;
                        bus_req          <= 1'b1;
                        state            <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        aborting <= abort;
                        state    <= S_DATA;
                    end else if (abort) begin
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (abort) aborting <= 1'b1;
                    if (beat_in) begin
                        if (beat == cur_len - 5'd1) begin
                            bus_req   <= 1'b0;
                            bus_addr  <= bus_addr + A_WIDTH'({cur_len, 1'b0});
                            remaining <= remaining - LEN_WIDTH'(cur_len);
                            state     <= S_RELEASE;
                        end else begin
                            beat <= beat + 5'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (abort) aborting <= 1'b1;
                    if (!bus_ack) begin
                        if (aborting || abort) begin
                            aborting <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus_data_in;
    end

endmodule

// File: tb/tb_bus_burst_reader.sv
// Bench for bus_burst_reader: SRAM-like responder, random-rate consumer and a
// burst-plan reference model computed straight from base address and length.
module tb_bus_burst_reader;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned LW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] num_words;
    logic          busy;
    logic          done;
    logic          bus_req;
    logic          bus_ack;
    logic          bus_wait;
    logic          bus_write;
    logic [1:0]    bus_burst_length;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data_in;
    logic          fifo_rd;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic [5:0]    fifo_count;

    bus_burst_reader #(
        .A_WIDTH    (AW),
        .D_WIDTH    (DW),
        .FIFO_DEPTH (DEPTH),
        .LEN_WIDTH  (LW),
        .BURST_CODE (2'b10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .base_addr        (base_addr),
        .num_words        (num_words),
        .busy             (busy),
        .done             (done),
        .bus_req          (bus_req),
        .bus_ack          (bus_ack),
        .bus_wait         (bus_wait),
        .bus_write        (bus_write),
        .bus_burst_length (bus_burst_length),
        .bus_addr         (bus_addr),
        .bus_data_in      (bus_data_in),
        .fifo_rd          (fifo_rd),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    logic [15:0] seed   = 16'h0;

    logic [31:0] txn_addr_q [$];
    logic [1:0]  txn_code_q [$];
    logic [15:0] got_q [$];
    logic [31:0] exp_addr_q [$];
    logic [1:0]  exp_code_q [$];
    logic [15:0] exp_data_q [$];

    int          slave_wait  = -1;
    bit          stall_en    = 1'b0;
    int unsigned words_given = 0;
    int unsigned pop_limit   = 0;
    int unsigned pops_done   = 0;
    int unsigned done_cnt    = 0;
    int unsigned max_count   = 0;
    bit          bw_seen     = 1'b0;

    int unsigned x_idx_t, x_p0, x_d0, x_num;
    bit          x_consume;

    function automatic logic [15:0] memfn(input logic [31:0] a);
        logic [31:0] h;
        h = (a >> 1) * 32'h9E37_79B1;
        return h[31:16] ^ seed;
    endfunction

    function automatic int unsigned code2len(input logic [1:0] c);
        case (c)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: word i comes from base+2i; bursts are 8 words while >=8 remain, else singles
    task automatic plan(input logic [31:0] base, input int unsigned num);
        logic [31:0] a;
        int unsigned rem, len;
        exp_addr_q.delete();
        exp_code_q.delete();
        exp_data_q.delete();
        a = {base[31:1], 1'b0};
        for (int unsigned i = 0; i < num; i++) exp_data_q.push_back(memfn(a + 32'(2 * i)));
        rem = num;
        while (rem > 0) begin
            len = (rem >= 8) ? 8 : 1;
            exp_addr_q.push_back(a);
            exp_code_q.push_back((len == 8) ? 2'b10 : 2'b00);
            a   = a + 32'(2 * len);
            rem = rem - len;
        end
    endtask

    task automatic slave_burst();
        logic [31:0] a;
        int unsigned n, w, gd;
        gd = $urandom_range(0, 2);
        for (int unsigned i = 0; i < gd; i++) begin
            @(negedge clk);
            if (reset || !bus_req) return;
        end
        a = bus_addr;
        n = code2len(bus_burst_length);
        txn_addr_q.push_back(a);
        txn_code_q.push_back(bus_burst_length);
        bus_ack  = 1'b1;
        bus_wait = 1'b1;
        w = (slave_wait >= 0) ? slave_wait : $urandom_range(0, 3);
        for (int unsigned i = 0; i < w + 1; i++) begin
            @(negedge clk);
            if (reset) return;
        end
        for (int unsigned j = 0; j < n; j++) begin
            if (stall_en && $urandom_range(0, 3) == 0) begin
                bus_wait = 1'b1;
                @(negedge clk);
                if (reset) return;
            end
            bus_wait    = 1'b0;
            bus_data_in = memfn(a + 32'(2 * j));
            words_given++;
            @(negedge clk);
            if (reset) return;
        end
        bus_wait = 1'b1;
        for (int i = 0; i < 20 && bus_req; i++) @(negedge clk);
    endtask

    initial begin : slave
        bus_ack     = 1'b0;
        bus_wait    = 1'b1;
        bus_data_in = '0;
        forever begin
            @(negedge clk);
            if (bus_req && !reset) slave_burst();
            bus_ack  = 1'b0;
            bus_wait = 1'b1;
        end
    end

    initial begin : consumer
        fifo_rd = 1'b0;
        forever begin
            @(negedge clk);
            fifo_rd = 1'b0;
            if (!reset && pops_done < pop_limit && !fifo_empty && $urandom_range(0, 3) != 0) begin
                fifo_rd = 1'b1;
                got_q.push_back(fifo_dout);
                pops_done++;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (int'(fifo_count) > max_count) max_count = fifo_count;
            if (bus_write) bw_seen = 1'b1;
        end
    end

    task automatic start_pulse(input logic [31:0] b, input int unsigned n);
        @(negedge clk);
        base_addr = b;
        num_words = LW'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic xfer_begin(input logic [31:0] b, input int unsigned n, input bit consume);
        plan(b, n);
        x_idx_t   = txn_addr_q.size();
        x_p0      = pops_done;
        x_d0      = done_cnt;
        x_num     = n;
        x_consume = consume;
        if (consume) pop_limit = x_p0 + n;
        start_pulse(b, n);
    endtask

    task automatic xfer_end(input string tag);
        int unsigned nt, nd;
        for (int i = 0; i < 4000 && done_cnt == x_d0; i++) @(negedge clk);
        check({tag, "_done_seen"}, done_cnt != x_d0, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - x_d0, 1);
        check({tag, "_ntxn"}, txn_addr_q.size() - x_idx_t, exp_addr_q.size());
        nt = txn_addr_q.size() - x_idx_t;
        if (nt > exp_addr_q.size()) nt = exp_addr_q.size();
        for (int unsigned i = 0; i < nt; i++) begin
            check({tag, "_addr"}, txn_addr_q[x_idx_t + i], exp_addr_q[i]);
            check({tag, "_code"}, txn_code_q[x_idx_t + i], exp_code_q[i]);
        end
        if (!x_consume) begin
            check({tag, "_count"}, fifo_count, x_num);
            pop_limit = x_p0 + x_num;
        end
        for (int i = 0; i < 2000 && pops_done != x_p0 + x_num; i++) @(negedge clk);
        check({tag, "_npop"}, pops_done - x_p0, x_num);
        nd = got_q.size() - x_p0;
        if (nd > x_num) nd = x_num;
        for (int unsigned i = 0; i < nd; i++)
            check({tag, "_data"}, got_q[x_p0 + i], exp_data_q[i]);
        @(negedge clk);
        check({tag, "_empty"}, fifo_empty, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin : main
        int unsigned g0, t0;
        bit req_seen;
        logic [31:0] rb;

        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        num_words = '0;
        seed      = 16'($urandom);
        repeat (3) @(negedge clk);
        check("rst_req", bus_req, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_code", bus_burst_length, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Two full bursts, fixed responder latency
        slave_wait = 2;
        stall_en   = 1'b0;
        xfer_begin(32'h100, 16, 0);
        xfer_end("t1");

        // Full burst then single-word tail
        slave_wait = -1;
        stall_en   = 1'b1;
        xfer_begin(32'h100, 11, 0);
        xfer_end("t2");

        // Stalled consumer: refill only when a whole burst fits
        xfer_begin(32'h1000, 64, 0);
        for (int i = 0; i < 3000 && fifo_count != 32; i++) @(negedge clk);
        check("t3_full", fifo_count, 32);
        req_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus_req) req_seen = 1'b1;
        end
        check("t3_req_idle", req_seen, 0);
        check("t3_ntxn4", txn_addr_q.size() - x_idx_t, 4);
        pop_limit = x_p0 + 8;
        for (int i = 0; i < 500 && pops_done != x_p0 + 8; i++) @(negedge clk);
        for (int i = 0; i < 500 && txn_addr_q.size() - x_idx_t < 5; i++) @(negedge clk);
        check("t3_refill", txn_addr_q.size() - x_idx_t, 5);
        x_consume = 1'b1;
        pop_limit = x_p0 + 64;
        xfer_end("t3");
        check("t3_no_overflow", max_count <= DEPTH, 1);

        // Abort in the middle of a burst
        stall_en = 1'b0;
        xfer_begin(32'h2000, 16, 0);
        g0 = words_given;
        for (int i = 0; i < 500 && fifo_count != 3; i++) @(negedge clk);
        check("t4_three", fifo_count, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 300 && done_cnt == x_d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t4_done_once", done_cnt - x_d0, 1);
        check("t4_burst_done", words_given - g0, 8);
        check("t4_ntxn", txn_addr_q.size() - x_idx_t, 1);
        check("t4_req", bus_req, 0);
        check("t4_empty", fifo_empty, 1);
        check("t4_count", fifo_count, 0);
        check("t4_busy", busy, 0);

        // Zero-length transfer: done two cycles after start, no bus traffic
        t0 = txn_addr_q.size();
        @(negedge clk);
        base_addr = 32'h500;
        num_words = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_busy1", busy, 1);
        check("t5_done1", done, 0);
        @(negedge clk);
        check("t5_done2", done, 1);
        check("t5_busy2", busy, 0);
        repeat (5) @(negedge clk);
        check("t5_no_txn", txn_addr_q.size() - t0, 0);

        // Start while busy is ignored
        stall_en = 1'b1;
        xfer_begin(32'h200, 16, 1);
        repeat (2) @(negedge clk);
        start_pulse(32'h900, 3);
        xfer_end("t5b");

        // Reset during a burst
        xfer_begin(32'h3000, 16, 0);
        for (int i = 0; i < 500 && fifo_count != 2; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_req", bus_req, 0);
        check("t6_count", fifo_count, 0);
        check("t6_busy", busy, 0);
        check("t6_empty", fifo_empty, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        xfer_begin(32'h4000, 10, 1);
        xfer_end("t6b");

        // Address wrap at the top of the map, odd base
        xfer_begin(32'hFFFF_FFF5, 12, 1);
        xfer_end("wrap");

        for (int t = 0; t < 6; t++) begin
            rb = $urandom;
            xfer_begin(rb, $urandom_range(0, 40), 1);
            xfer_end("rnd");
        end

        check("bus_write_low", bw_seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
